program_sequencer: RTL and testbench

- Upstream stage of the instruction decoder. Generates the program-memory address `pm_addr` each cycle; the program-memory word at that address becomes the decoder's `next_instr`.
- Consumes the decoder's `jmp`, `jmp_nz` and `ir_nibble` (jump target), plus the datapath zero flag.
- Adds a small return-address stack (call/ret), a hold (stall) input and a retired-instruction counter for debug.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/program_sequencer_if.sv | 38 +++
 rtl/ret_addr_stack.sv | 56 +++++
 rtl/program_sequencer.sv | 122 ++++++++++++
 tb/tb_program_sequencer.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared sequencer definitions: address width default, next-pc select codes, jump target builder.
// No logic; types and helpers only.
// No flow control.
package cpu_pkg;

    localparam int PM_ADDR_W_DFLT = 8;

    // Source of the next program-memory address, listed in priority order.
    typedef enum logic [2:0] {
        NPC_HOLD,
        NPC_JMP,
        NPC_CALL,
        NPC_RET,
        NPC_JNZ,
        NPC_INC
    } npc_sel_e;

    // Jump targets land on 16-word boundaries: the nibble becomes the upper address bits.
    function automatic logic [7:0] build_tgt(input logic [3:0] nibble);
        return {nibble, 4'h0};
    endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Control and status bundle between the decoder and the program sequencer.
// No logic; wires only.
// No flow control: hold is the only stall mechanism.
interface program_sequencer_if
    import cpu_pkg::*;
#(
    parameter int PM_ADDR_W   = PM_ADDR_W_DFLT,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 16
);
    localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

    logic                 hold;
    logic                 jmp;
    logic                 jmp_nz;
    logic                 call;
    logic                 ret;
    logic [3:0]           jmp_addr;
    logic                 dont_jmp;
    logic [PM_ADDR_W-1:0] pm_addr;
    logic [PM_ADDR_W-1:0] pc;
    logic                 stack_err;
    logic [LVL_W-1:0]     stack_lvl;
    logic [CNT_W-1:0]     instr_cnt;

    // Decoder side.
    modport master (
        output hold, jmp, jmp_nz, call, ret, jmp_addr, dont_jmp,
        input  pm_addr, pc, stack_err, stack_lvl, instr_cnt
    );

    // Sequencer side.
    modport slave (
        input  hold, jmp, jmp_nz, call, ret, jmp_addr, dont_jmp,
        output pm_addr, pc, stack_err, stack_lvl, instr_cnt
    );

endinterface

// File: rtl/ret_addr_stack.sv
// LIFO of return addresses with level, full/empty and combinational top-of-stack.
// Latency: push/pop take effect on the next clk edge; top is combinational.
// Backpressure: push when full and pop when empty are ignored; the caller flags them.
module ret_addr_stack #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_push,
    input  logic                           i_pop,
    input  logic [DATA_W-1:0]              i_dat,
    output logic                           o_full,
    output logic                           o_empty,
    output logic [$clog2(DEPTH):0]         o_lvl,
    output logic [DATA_W-1:0]              o_top
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LVL_W = IDX_W + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [LVL_W-1:0]  r_lvl;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_top_idx;
    logic              w_do_push;
    logic              w_do_pop;

    // Write slot is the current level; the top sits one below it.
    assign w_wr_idx  = r_lvl[IDX_W-1:0];
    assign w_top_idx = w_wr_idx - IDX_W'(1);
    assign o_full    = (r_lvl == LVL_W'(DEPTH));
    assign o_empty   = (r_lvl == '0);
    assign o_lvl     = r_lvl;
    assign o_top     = r_mem[w_top_idx];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty && !i_push;

    // Occupancy pointer; only state that needs reset, stale entries are invalid once level is 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lvl <= '0;
        end else if (w_do_push) begin
            r_lvl <= r_lvl + LVL_W'(1);
        end else if (w_do_pop) begin
            r_lvl <= r_lvl - LVL_W'(1);
        end
    end

    // Entry storage, written on push only.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= i_dat;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Program-memory address generator with jump, conditional jump, call/ret stack, hold and retired counter.
// Latency: pm_addr is combinational from controls; pc follows pm_addr one edge later.
// Backpressure: hold freezes pc, stack and counter and discards any control asserted with it.
module program_sequencer
    import cpu_pkg::*;
#(
    parameter int PM_ADDR_W   = PM_ADDR_W_DFLT,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                sync_reset,
    program_sequencer_if.slave  bus
);
    localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

    logic [PM_ADDR_W-1:0] r_pc;
    logic                 r_err;
    logic [CNT_W-1:0]     r_cnt;

    logic [PM_ADDR_W-1:0] w_pc_inc;
    logic [PM_ADDR_W-1:0] w_tgt;
    logic [PM_ADDR_W-1:0] w_top;
    logic [PM_ADDR_W-1:0] w_pm_addr;
    logic [LVL_W-1:0]     w_lvl;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_err_set;
    npc_sel_e             w_sel;

    assign w_pc_inc = r_pc + PM_ADDR_W'(1);
    assign w_tgt    = PM_ADDR_W'(build_tgt(bus.jmp_addr));

    // Priority select of the next-address source; a ret on an empty stack does not match.
    always_comb begin
        w_sel = NPC_INC;
        if (bus.hold) begin
            w_sel = NPC_HOLD;
        end else if (bus.jmp) begin
            w_sel = NPC_JMP;
        end else if (bus.call) begin
            w_sel = NPC_CALL;
        end else if (bus.ret && !w_empty) begin
            w_sel = NPC_RET;
        end else if (bus.jmp_nz && !bus.dont_jmp) begin
            w_sel = NPC_JNZ;
        end
    end

    // Next-address mux; forced to zero while reset is asserted.
    always_comb begin
        w_pm_addr = w_pc_inc;
        case (w_sel)
            NPC_HOLD: w_pm_addr = r_pc;
            NPC_JMP:  w_pm_addr = w_tgt;
            NPC_CALL: w_pm_addr = w_tgt;
            NPC_RET:  w_pm_addr = w_top;
            NPC_JNZ:  w_pm_addr = w_tgt;
            default:  w_pm_addr = w_pc_inc;
        endcase
        if (sync_reset) begin
            w_pm_addr = '0;
        end
    end

    // Stack actions: a call on a full stack still jumps but the push is dropped.
    assign w_push    = (w_sel == NPC_CALL) && !w_full && !sync_reset;
    assign w_pop     = (w_sel == NPC_RET) && !sync_reset;
    assign w_err_set = ((w_sel == NPC_CALL) && w_full) ||
                       (!bus.hold && !bus.jmp && !bus.call && bus.ret && w_empty);

    ret_addr_stack #(
        .DATA_W (PM_ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (sync_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_dat   (w_pc_inc),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_lvl   (w_lvl),
        .o_top   (w_top)
    );

    // Current address register; hold re-presents pc through the mux so no enable is needed.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_pc <= '0;
        end else begin
            r_pc <= w_pm_addr;
        end
    end

    // Sticky overflow/underflow flag, cleared only by reset.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    // Retired-instruction counter, saturating at all-ones, frozen by hold.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            r_cnt <= '0;
        end else if (!bus.hold && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign bus.pm_addr   = w_pm_addr;
    assign bus.pc        = r_pc;
    assign bus.stack_err = r_err;
    assign bus.stack_lvl = w_lvl;
    assign bus.instr_cnt = r_cnt;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: vector table, corner-case sequences, random vs reference model.
// Counter width is reduced so saturation is reachable in a short run.
// Inputs driven after the falling edge, outputs sampled 1 time unit after either drive or rising edge.
module tb_program_sequencer;

    localparam int AW  = 8;
    localparam int SD  = 4;
    localparam int CW  = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic sync_reset = 1'b0;

    always #5 clk = ~clk;

    program_sequencer_if #(.PM_ADDR_W(AW), .STACK_DEPTH(SD), .CNT_W(CW)) bus ();

    program_sequencer #(.PM_ADDR_W(AW), .STACK_DEPTH(SD), .CNT_W(CW)) dut (
        .clk        (clk),
        .sync_reset (sync_reset),
        .bus        (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model state: addresses as plain integers, stack as a queue (back = top).
    int m_pc;
    int m_err;
    int m_cnt;
    int m_stk[$];

    typedef struct {
        logic       h, j, jn, dj, c, r;
        logic [3:0] nib;
        int         pm, lvl, err, cnt;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = 0;
        m_err = 0;
        m_cnt = 0;
        m_stk.delete();
    endtask

    function automatic int model_pm(input logic h, j, jn, dj, c, r, input logic [3:0] nib);
        int tgt;
        tgt = int'(nib) * 16;
        if (h)                    return m_pc;
        if (j)                    return tgt;
        if (c)                    return tgt;
        if (r && m_stk.size() > 0) return m_stk[m_stk.size() - 1];
        if (jn && !dj)            return tgt;
        return (m_pc + 1) % (1 << AW);
    endfunction

    task automatic drive(input logic h, j, jn, dj, c, r, input logic [3:0] nib);
        bus.hold     = h;
        bus.jmp      = j;
        bus.jmp_nz   = jn;
        bus.dont_jmp = dj;
        bus.call     = c;
        bus.ret      = r;
        bus.jmp_addr = nib;
    endtask

    // One clock cycle, entered and left just after a falling edge.
    task automatic cycle(input logic h, j, jn, dj, c, r, input logic [3:0] nib);
        int exp_pm;
        drive(h, j, jn, dj, c, r, nib);
        #1;
        exp_pm = model_pm(h, j, jn, dj, c, r, nib);
        chk("pm_addr", int'(bus.pm_addr), exp_pm);
        @(posedge clk);
        if (!h) begin
            if (!j) begin
                if (c) begin
                    if (m_stk.size() < SD) m_stk.push_back((m_pc + 1) % (1 << AW));
                    else                   m_err = 1;
                end else if (r) begin
                    if (m_stk.size() > 0)  void'(m_stk.pop_back());
                    else                   m_err = 1;
                end
            end
            if (m_cnt < CMAX) m_cnt++;
        end
        m_pc = exp_pm;
        #1;
        chk("pc", int'(bus.pc), m_pc);
        chk("stack_lvl", int'(bus.stack_lvl), m_stk.size());
        chk("stack_err", int'(bus.stack_err), m_err);
        chk("instr_cnt", int'(bus.instr_cnt), m_cnt);
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 4'h0);
    endtask

    task automatic do_reset();
        sync_reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 4'h0);
        #1;
        chk("rst_pm", int'(bus.pm_addr), 0);
        chk("rst_pc", int'(bus.pc), 0);
        chk("rst_lvl", int'(bus.stack_lvl), 0);
        chk("rst_err", int'(bus.stack_err), 0);
        chk("rst_cnt", int'(bus.instr_cnt), 0);
        @(posedge clk);
        @(negedge clk);
        sync_reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_snap;
        logic h, j, jn, dj, c, r;
        logic [3:0] nib;

        //           h  j  jn dj c  r  nib    pm     lvl err cnt
        tbl[0]  = '{0, 0, 0, 0, 0, 0, 4'h0, 'h06, 0, 0, 6};
        tbl[1]  = '{0, 0, 0, 0, 0, 0, 4'h0, 'h07, 0, 0, 7};
        tbl[2]  = '{0, 1, 0, 0, 0, 0, 4'hA, 'hA0, 0, 0, 8};
        tbl[3]  = '{0, 0, 1, 0, 0, 0, 4'h3, 'h30, 0, 0, 9};
        tbl[4]  = '{0, 0, 1, 1, 0, 0, 4'h3, 'h31, 0, 0, 10};
        tbl[5]  = '{0, 1, 0, 0, 0, 0, 4'h1, 'h10, 0, 0, 11};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 4'h0, 'h11, 0, 0, 12};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 4'h0, 'h12, 0, 0, 13};
        tbl[8]  = '{0, 0, 0, 0, 1, 0, 4'h5, 'h50, 1, 0, 14};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 4'h0, 'h51, 1, 0, 15};
        tbl[10] = '{0, 0, 0, 0, 0, 1, 4'h0, 'h13, 0, 0, 16};
        tbl[11] = '{0, 0, 0, 0, 1, 1, 4'h2, 'h20, 1, 0, 17};
        tbl[12] = '{0, 1, 0, 0, 1, 1, 4'h4, 'h40, 1, 0, 18};
        tbl[13] = '{1, 1, 0, 0, 0, 0, 4'h7, 'h40, 1, 0, 18};
        tbl[14] = '{0, 0, 0, 0, 0, 1, 4'h0, 'h14, 0, 0, 19};
        tbl[15] = '{0, 0, 0, 0, 0, 1, 4'h0, 'h15, 0, 1, 20};
        tbl[16] = '{0, 0, 0, 0, 0, 0, 4'h0, 'h16, 0, 1, 21};

        drive(0, 0, 0, 0, 0, 0, 4'h0);
        #1;
        do_reset();

        // Free-running count from reset, pc one cycle behind pm_addr.
        for (int i = 1; i <= 5; i++) begin
            chk("t1_pc_before", int'(bus.pc), i - 1);
            idle();
            chk("t1_pc_after", int'(bus.pc), i);
        end
        chk("t1_cnt", int'(bus.instr_cnt), 5);

        // Vector table: jumps, conditional jumps, call/ret, priorities, hold, empty ret.
        for (int i = 0; i < 17; i++) begin
            cycle(tbl[i].h, tbl[i].j, tbl[i].jn, tbl[i].dj, tbl[i].c, tbl[i].r, tbl[i].nib);
            chk($sformatf("tbl%0d_pc", i), int'(bus.pc), tbl[i].pm);
            chk($sformatf("tbl%0d_lvl", i), int'(bus.stack_lvl), tbl[i].lvl);
            chk($sformatf("tbl%0d_err", i), int'(bus.stack_err), tbl[i].err);
            chk($sformatf("tbl%0d_cnt", i), int'(bus.instr_cnt), tbl[i].cnt);
        end

        // Address wrap from 0xFF to 0x00.
        cycle(0, 1, 0, 0, 0, 0, 4'hF);
        for (int i = 0; i < 15; i++) idle();
        chk("wrap_ff", int'(bus.pc), 'hFF);
        idle();
        chk("wrap_00", int'(bus.pc), 'h00);

        // Stack overflow and LIFO unwind, then underflow.
        do_reset();
        for (int k = 1; k <= 5; k++) cycle(0, 0, 0, 0, 1, 0, 4'(k));
        chk("ovf_lvl", int'(bus.stack_lvl), 4);
        chk("ovf_err", int'(bus.stack_err), 1);
        chk("ovf_pc", int'(bus.pc), 'h50);
        for (int k = 4; k >= 1; k--) begin
            cycle(0, 0, 0, 0, 0, 1, 4'h0);
            chk("lifo_pc", int'(bus.pc), ((k - 1) * 16) + 1);
        end
        chk("lifo_lvl", int'(bus.stack_lvl), 0);
        cycle(0, 0, 0, 0, 0, 1, 4'h0);
        chk("udf_pc", int'(bus.pc), 'h02);
        chk("udf_err", int'(bus.stack_err), 1);
        chk("udf_lvl", int'(bus.stack_lvl), 0);

        // Hold with jmp asserted: nothing moves.
        cycle(0, 1, 0, 0, 0, 0, 4'h6);
        idle();
        cnt_snap = int'(bus.instr_cnt);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 1, 0, 0, 0, 0, 4'h9);
            chk("hold_pc", int'(bus.pc), 'h61);
            chk("hold_cnt", int'(bus.instr_cnt), cnt_snap);
        end

        // Asynchronous reset between edges.
        drive(0, 0, 0, 0, 0, 0, 4'h0);
        #2;
        sync_reset = 1'b1;
        #1;
        chk("arst_pc", int'(bus.pc), 0);
        chk("arst_pm", int'(bus.pm_addr), 0);
        chk("arst_lvl", int'(bus.stack_lvl), 0);
        chk("arst_err", int'(bus.stack_err), 0);
        chk("arst_cnt", int'(bus.instr_cnt), 0);
        @(negedge clk);
        sync_reset = 1'b0;
        model_reset();
        idle();
        chk("arst_first_pc", int'(bus.pc), 1);

        // Random traffic against the model; ret and jmp_nz never asserted together.
        do_reset();
        for (int i = 0; i < 900; i++) begin
            h   = ($urandom % 10) == 0;
            j   = ($urandom % 10) == 0;
            c   = ($urandom % 6) == 0;
            r   = ($urandom % 5) == 0;
            jn  = !r && (($urandom % 4) == 0);
            dj  = $urandom % 2;
            nib = 4'($urandom);
            cycle(h, j, jn, dj, c, r, nib);
        end

        // Counter saturation.
        for (int i = 0; i < 260; i++) idle();
        chk("cnt_sat", int'(bus.instr_cnt), CMAX);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
